// File: rtl/adder_sequencer.sv
// Nibble-serial adder/subtractor: one 4-bit ripple slice reused per cycle,
// valid/ready on both request and result sides.
module adder_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    a4, b4, s4;
  logic          c4;
  logic          last;

  always_comb begin
    a4 = a_q[{cnt_q, 2'b00} +: 4];
    b4 = b_q[{cnt_q, 2'b00} +: 4];
    {c4, s4} = {1'b0, a4} + {1'b0, b4} + {4'b0000, carry_q};
    last = (cnt_q == CW'(NIBBLES - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = s4;
        carry_d = c4;
        if (last) begin
          // s4[3] is the result sign bit; b_q is already the effective operand
          cout_d  = c4;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (s4[3] != a_q[W-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer (NIBBLES=4): latency, arithmetic,
// back-pressure, ignored requests while busy, mid-run reset.
module tb_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;

  adder_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 4);
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input int stall);
    a = va; b = vb; cin = vc; sub = vs;
    in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_v"}, out_valid, 1);
      check({tag, "_stall_s"}, {sum, cout, overflow}, {es, ec, eo});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_v"}, out_valid, 0);
    check({tag, "_idle_r"}, in_ready, 1);
    check({tag, "_hold"}, {sum, cout, overflow}, {es, ec, eo});
  endtask

  initial begin
    int seen;
    tick();
    tick();
    check("rst_state",
          {in_ready, out_valid, busy, cout, overflow}, 5'b10000);
    check("rst_sum", sum, 0);

    // first acceptance in the first cycle after reset release
    rst = 1'b0;
    run_op("r031", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0);
    run_op("wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0);
    run_op("povf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    run_op("cin1", 16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0, 0);
    run_op("mix", 16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0);
    run_op("sub57", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0);
    run_op("subov", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
    run_op("subeq", 16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0, 0);
    run_op("stall", 16'h0F0F, 16'h0101, 0, 0, 16'h1010, 0, 0, 5);

    // requests while busy are ignored
    a = 16'h00FF; b = 16'h0001; cin = 0; sub = 0;
    in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_ready) seen++;
      tick();
    end
    check("busy_rdy", seen, 0);
    check("busy_v", out_valid, 1);
    check("busy_sum", {sum, cout, overflow}, {16'h0100, 1'b0, 1'b0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("reacc_r", {in_ready, busy}, 2'b10);
    tick();
    in_valid = 1'b0;
    check("reacc_b", busy, 1);
    wait_done("reacc");
    check("reacc_sum", {sum, cout, overflow}, {16'hFFFE, 1'b1, 1'b0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset after nibble 1 discards the partial result
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state",
          {in_ready, out_valid, busy, cout, overflow}, 5'b10000);
    check("mrst_sum", sum, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("mrst_nov", seen, 0);
    run_op("after", 16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
